// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Instruction fetch queue plus IF/ID pipeline register. Buffers
//            fetched words from IF in a small FIFO so that instruction-memory
//            latency is decoupled from ID stalls. It also inserts flush and
//            underflow bubbles, and tracks the restart PC for delay slots.
// Ports    : clock, reset          - clock and synchronous active-high reset
//            IF_Valid / IF_Ready   - fetch handshake (IF_Ready = count < QDEPTH)
//            IF_Instruction, IF_PC, IF_PCAdd4, IF_IsBDS - fetched entry
//            IF_Flush              - kill queued / in-flight instructions
//            ID_Stall              - hold the ID register
//            ID_Instruction, ID_PCAdd4, ID_RestartPC, ID_IsBDS,
//            ID_IsFlushed          - IF/ID pipeline register outputs
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int QDEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IF_Valid,
    output logic        IF_Ready,
    input  logic [31:0] IF_Instruction,
    input  logic [31:0] IF_PC,
    input  logic [31:0] IF_PCAdd4,
    input  logic        IF_IsBDS,
    input  logic        IF_Flush,
    input  logic        ID_Stall,
    output logic [31:0] ID_Instruction,
    output logic [31:0] ID_PCAdd4,
    output logic [31:0] ID_RestartPC,
    output logic        ID_IsBDS,
    output logic        ID_IsFlushed
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;

    // Queue storage: one entry per slot holding {Instruction, PC, PCAdd4, IsBDS}
    logic [31:0]   q_instr  [QDEPTH];
    logic [31:0]   q_pc     [QDEPTH];
    logic [31:0]   q_pcadd4 [QDEPTH];
    logic          q_bds    [QDEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic          enq;
    logic          deq;
    logic          not_empty;

    // Ready depends only on the registered count, so there is no combinational
    // path from ID_Stall or IF_Flush back to the fetch stage.
    assign IF_Ready  = (count < CW'(QDEPTH));
    assign not_empty = (count != '0);
    assign enq       = IF_Valid & IF_Ready & ~IF_Flush;
    assign deq       = ~ID_Stall & ~IF_Flush & not_empty;

    // Storage needs no reset: an entry is only read once count says it is valid.
    always_ff @(posedge clock) begin
        if (enq) begin
            q_instr[tail]  <= IF_Instruction;
            q_pc[tail]     <= IF_PC;
            q_pcadd4[tail] <= IF_PCAdd4;
            q_bds[tail]    <= IF_IsBDS;
        end
    end

    // Queue pointers and occupancy. QDEPTH is a power of two, so the pointers
    // wrap naturally at their bit width.
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (IF_Flush) begin
            // A flush empties the queue even while ID is stalled.
            head  <= tail;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + AW'(1);
            end
            if (deq) begin
                head <= head + AW'(1);
            end
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clock) begin
        if (reset) begin
            ID_Instruction <= '0;
            ID_PCAdd4      <= '0;
            ID_RestartPC   <= '0;
            ID_IsBDS       <= 1'b0;
            ID_IsFlushed   <= 1'b0;
        end else if (ID_Stall) begin
            // Hold everything, including while a flush empties the queue.
        end else if (IF_Flush) begin
            ID_Instruction <= '0;
            ID_IsBDS       <= 1'b0;
            ID_IsFlushed   <= 1'b1;
        end else if (not_empty) begin
            ID_Instruction <= q_instr[head];
            ID_PCAdd4      <= q_pcadd4[head];
            ID_IsBDS       <= q_bds[head];
            ID_IsFlushed   <= 1'b0;
            // A delay slot restarts at its branch. The branch went through ID
            // just before the slot, so the current value is already that PC.
            if (!q_bds[head]) begin
                ID_RestartPC <= q_pc[head];
            end
        end else begin
            // Underflow bubble. PCAdd4 and RestartPC keep their last values.
            ID_Instruction <= '0;
            ID_IsBDS       <= 1'b0;
            ID_IsFlushed   <= 1'b0;
        end
    end

endmodule
`default_nettype wire
